// File: rtl/ddr4_bank_arbiter_pkg.sv
// Shared types and constants for the kernel-side DDR4 bank arbiter.
package kernel_mem_pkg;

  localparam int ADDR_W  = 33;
  localparam int DATA_W  = 512;
  localparam int BE_W    = DATA_W / 8;
  localparam int BC_W    = 5;
  localparam int MAX_REQ = 4;
  localparam int ID_W    = 2;   // wide enough for up to MAX_REQ requesters

  // One outstanding read burst: who asked for it and how many beats it returns.
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [BC_W-1:0] bc;
  } rd_tag_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } arb_state_t;

  // A burstcount of zero is accounted as a single beat.
  function automatic logic [BC_W-1:0] bc_norm(input logic [BC_W-1:0] bc);
    return (bc == '0) ? BC_W'(1) : bc;
  endfunction

endpackage

// File: rtl/ddr4_bank_arbiter_if.sv
// Requester-side and bank-side Avalon-MM signals of one arbiter instance.
interface ddr4_bank_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = kernel_mem_pkg::ADDR_W,
  parameter int DATA_W  = kernel_mem_pkg::DATA_W,
  parameter int BC_W    = kernel_mem_pkg::BC_W
);
  localparam int BE_W = DATA_W / 8;

  // Kernel masters (packed per requester)
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*BE_W-1:0]   req_byteenable;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ*BC_W-1:0]   req_burstcount;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;

  // Bank port
  logic [ADDR_W-1:0]         ddr_address;
  logic [BE_W-1:0]           ddr_byteenable;
  logic                      ddr_read;
  logic                      ddr_write;
  logic [DATA_W-1:0]         ddr_writedata;
  logic [BC_W-1:0]           ddr_burstcount;
  logic                      ddr_waitrequest;
  logic [DATA_W-1:0]         ddr_readdata;
  logic                      ddr_readdatavalid;

  // Arbiter view: slave to the kernel masters, master to the bank.
  modport slave (
    input  req_address, req_byteenable, req_read, req_write, req_writedata, req_burstcount,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output ddr_address, ddr_byteenable, ddr_read, ddr_write, ddr_writedata, ddr_burstcount,
    input  ddr_waitrequest, ddr_readdata, ddr_readdatavalid
  );

  // Environment view: kernel masters plus the bank model.
  modport master (
    output req_address, req_byteenable, req_read, req_write, req_writedata, req_burstcount,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  ddr_address, ddr_byteenable, ddr_read, ddr_write, ddr_writedata, ddr_burstcount,
    output ddr_waitrequest, ddr_readdata, ddr_readdatavalid
  );

endinterface

// File: rtl/ddr4_bank_arbiter_tag_fifo.sv
// Read-tag FIFO: remembers requester id and beat count of each outstanding read burst.
module ddr_rsp_tag_fifo
  import kernel_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  rd_tag_t push_tag,
  input  logic    pop,
  output rd_tag_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  rd_tag_t     mem_q [DEPTH];
  rd_tag_t     mem_d [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // Next pointers and storage; a full FIFO refuses a push even when popping.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_q[AW-1:0]] = push_tag;
      wr_d                = wr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ddr4_bank_arbiter.sv
// Round-robin arbiter sharing one DDR4 bank port between NUM_REQ kernel masters.
module ddr4_bank_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 8,
  parameter int ADDR_W    = kernel_mem_pkg::ADDR_W,
  parameter int DATA_W    = kernel_mem_pkg::DATA_W,
  parameter int BC_W      = kernel_mem_pkg::BC_W
) (
  input  logic               clock_reset_clk,
  input  logic               clock_reset_reset_reset_n,
  ddr4_bank_arbiter_if.slave bus,
  output logic               err_unexpected_rdv
);
  import kernel_mem_pkg::*;

  localparam int BE_W = DATA_W / 8;

  logic clk, rst_n;
  assign clk   = clock_reset_clk;
  assign rst_n = clock_reset_reset_reset_n;

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] lock_q, lock_d;
  logic [BC_W-1:0] beats_q, beats_d;
  logic [BC_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic            err_q, err_d;

  logic [NUM_REQ-1:0] req_any;
  logic               found;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    grant_id;
  logic               in_burst;

  logic               sel_rd, sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BE_W-1:0]    sel_be;
  logic [DATA_W-1:0]  sel_wd;
  logic [BC_W-1:0]    sel_bc;
  logic [BC_W-1:0]    sel_bc_n;

  logic               cmd_rd, cmd_wr;
  logic               ddr_rd, ddr_wr, accept;
  logic [NUM_REQ-1:0] wreq;
  logic [NUM_REQ-1:0] rdv;

  rd_tag_t            push_tag, head;
  logic               tag_push, tag_pop, tag_full, tag_empty;
  logic               rdv_hit, last_beat;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (int'(id) >= NUM_REQ - 1) return '0;
    return id + ID_W'(1);
  endfunction

  assign req_any  = bus.req_read | bus.req_write;
  assign in_burst = (state_q == WBURST);
  assign grant_id = in_burst ? lock_q : win;

  // Round-robin search from the pointer upward, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == (int'(rr_q) + k) % NUM_REQ) && req_any[j]) begin
          found = 1'b1;
          win   = ID_W'(j);
        end
      end
    end
  end

  // Mux the granted requester's command fields onto the bank side.
  always_comb begin
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_be   = '0;
    sel_wd   = '0;
    sel_bc   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_rd   = bus.req_read[i];
        sel_wr   = bus.req_write[i];
        sel_addr = bus.req_address[i*ADDR_W +: ADDR_W];
        sel_be   = bus.req_byteenable[i*BE_W +: BE_W];
        sel_wd   = bus.req_writedata[i*DATA_W +: DATA_W];
        sel_bc   = bus.req_burstcount[i*BC_W +: BC_W];
      end
    end
  end

  assign sel_bc_n = bc_norm(sel_bc);

  // Read wins over write from the same requester; inside a burst only writes pass.
  assign cmd_rd = !in_burst && found && sel_rd;
  assign cmd_wr = in_burst ? sel_wr : (found && sel_wr && !sel_rd);
  assign ddr_rd = rst_n && cmd_rd && !tag_full;
  assign ddr_wr = rst_n && cmd_wr;
  assign accept = (ddr_rd || ddr_wr) && !bus.ddr_waitrequest;

  // Per-requester stall: everyone but the grantee waits, and everyone waits in reset.
  always_comb begin
    wreq = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      wreq[i] = !rst_n || !(in_burst || found) || (grant_id != ID_W'(i)) ||
                bus.ddr_waitrequest || (cmd_rd && tag_full);
    end
  end

  assign bus.req_waitrequest = wreq;
  assign bus.ddr_address     = sel_addr;
  assign bus.ddr_byteenable  = sel_be;
  assign bus.ddr_writedata   = sel_wd;
  assign bus.ddr_burstcount  = sel_bc;
  assign bus.ddr_read        = ddr_rd;
  assign bus.ddr_write       = ddr_wr;

  // Command FSM: single-beat commands stay in IDLE, multi-beat writes lock the grant.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ddr_rd) begin
            rr_d = next_id(win);
          end else if (sel_bc_n > BC_W'(1)) begin
            state_d = WBURST;
            lock_d  = win;
            beats_d = sel_bc_n - BC_W'(1);
          end else begin
            rr_d = next_id(win);
          end
        end
      end
      WBURST: begin
        if (accept) begin
          beats_d = beats_q - BC_W'(1);
          if (beats_q == BC_W'(1)) begin
            state_d = IDLE;
            rr_d    = next_id(lock_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tag_push = ddr_rd && !bus.ddr_waitrequest;
  assign push_tag = '{id: win, bc: sel_bc_n};

  ddr_rsp_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .head     (head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assign rdv_hit   = bus.ddr_readdatavalid && !tag_empty;
  assign last_beat = (rsp_cnt_q + BC_W'(1)) >= head.bc;
  assign tag_pop   = rdv_hit && last_beat;

  // Response routing: beats go to the head tag's owner; the last beat retires the tag.
  always_comb begin
    rdv       = '0;
    rsp_cnt_d = rsp_cnt_q;
    err_d     = err_q || (bus.ddr_readdatavalid && tag_empty);
    for (int i = 0; i < NUM_REQ; i++) begin
      rdv[i] = rdv_hit && (head.id == ID_W'(i));
    end
    if (rdv_hit) begin
      rsp_cnt_d = last_beat ? '0 : rsp_cnt_q + BC_W'(1);
    end
  end

  assign bus.req_readdata      = bus.ddr_readdata;
  assign bus.req_readdatavalid = rdv;
  assign err_unexpected_rdv    = err_q;

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      lock_q    <= '0;
      beats_q   <= '0;
      rsp_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      beats_q   <= beats_d;
      rsp_cnt_q <= rsp_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr4_bank_arbiter.sv
// Self-checking bench for ddr4_bank_arbiter (NUM_REQ=2, TAG_DEPTH=4).
module tb_ddr4_bank_arbiter;
  import kernel_mem_pkg::*;

  localparam int NR = 2;
  localparam int TD = 4;
  localparam int AW = 33;
  localparam int DW = 512;
  localparam int BW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  always #5 clk = ~clk;

  ddr4_bank_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BC_W(BW)) bus ();

  ddr4_bank_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD), .ADDR_W(AW), .DATA_W(DW), .BC_W(BW)) dut (
    .clock_reset_clk           (clk),
    .clock_reset_reset_reset_n (rst_n),
    .bus                       (bus),
    .err_unexpected_rdv        (err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NR-1:0] oh;
    logic [63:0]   data;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        dw;
    logic        dr_e;
    logic        dw_e;
    logic [1:0]  wq_e;
    logic [32:0] a_e;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_bc(input int id, input logic [BW-1:0] bc);
    bus.req_burstcount[id*BW +: BW] = bc;
  endtask

  // Called at a falling edge; samples 1 time unit before each rising edge.
  task automatic wait_accept(input int id, input int budget, output int cyc,
                             output logic [32:0] a, output logic [4:0] bc,
                             output logic r, output logic w);
    cyc = 0; a = '0; bc = '0; r = 1'b0; w = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #4;
      if (!bus.req_waitrequest[id[0]]) begin
        a = bus.ddr_address; bc = bus.ddr_burstcount;
        r = bus.ddr_read; w = bus.ddr_write; cyc = c + 1;
      end
      @(negedge clk);
      if (cyc != 0) break;
    end
  endtask

  // One bank read beat; the expected routing is queued when it is driven.
  task automatic beat(input logic [NR-1:0] oh, input logic [63:0] d);
    rsp_t e;
    bus.ddr_readdatavalid = 1'b1;
    bus.ddr_readdata      = DW'(d);
    if (oh != '0) begin
      e.oh = oh; e.data = d;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.ddr_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_waitreq", bus.req_waitrequest, 2'b11);
    chk("rst_ddr_cmd", {bus.ddr_read, bus.ddr_write}, 2'b00);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Response monitor: every valid beat must match the head of the scoreboard.
  initial begin
    forever begin
      rsp_t e;
      @(negedge clk);
      #3;
      if (rst_n && (bus.req_readdatavalid != '0)) begin
        if (sb.size() == 0) begin
          chk("rdv_unexpected", bus.req_readdatavalid, 2'b00);
        end else begin
          e = sb.pop_front();
          chk("rdv_onehot", bus.req_readdatavalid, e.oh);
          chk("rdv_data", bus.req_readdata[63:0], e.data);
        end
      end
    end
  end

  initial begin
    int cyc;
    int nb;
    int nc;
    logic acc;
    logic [32:0] a;
    logic [4:0] bc;
    logic r, w;

    vt[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 33'h100};
    vt[1] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 33'h100};
    vt[2] = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 33'h200};
    vt[3] = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 33'h100};
    vt[4] = '{2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b01, 33'h200};
    vt[5] = '{2'b01, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 33'h100};
    vt[6] = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 33'h100};
    vt[7] = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 33'h100};
    vt[8] = '{2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 2'b11, 33'h100};

    bus.req_address       = {33'h200, 33'h100};
    bus.req_byteenable    = '1;
    bus.req_read          = '0;
    bus.req_write         = '0;
    bus.req_writedata     = '0;
    bus.req_burstcount    = '0;
    bus.ddr_waitrequest   = 1'b0;
    bus.ddr_readdata      = '0;
    bus.ddr_readdatavalid = 1'b0;

    // Reset state
    #1;
    chk("init_waitreq", bus.req_waitrequest, 2'b11);
    chk("init_ddr_cmd", {bus.ddr_read, bus.ddr_write}, 2'b00);
    chk("init_rdv", bus.req_readdatavalid, 2'b00);
    chk("init_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational grant vectors (pointer at 0, inputs removed before the edge)
    set_bc(0, 5'd2); set_bc(1, 5'd3);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.req_read = vt[i].rd; bus.req_write = vt[i].wr; bus.ddr_waitrequest = vt[i].dw;
      #1;
      chk($sformatf("vec%0d_ddr_read", i), bus.ddr_read, vt[i].dr_e);
      chk($sformatf("vec%0d_ddr_write", i), bus.ddr_write, vt[i].dw_e);
      chk($sformatf("vec%0d_waitreq", i), bus.req_waitrequest, vt[i].wq_e);
      if (vt[i].dr_e || vt[i].dw_e)
        chk($sformatf("vec%0d_addr", i), bus.ddr_address, vt[i].a_e);
      #1;
      bus.req_read = '0; bus.req_write = '0; bus.ddr_waitrequest = 1'b0;
    end

    // req0 burst read of 4 beats
    @(negedge clk);
    set_bc(0, 5'd4);
    bus.req_read[0] = 1'b1;
    wait_accept(0, 4, cyc, a, bc, r, w);
    bus.req_read = '0;
    chk("rd4_cycles", cyc, 1);
    chk("rd4_addr", a, 33'h100);
    chk("rd4_bc", bc, 5'd4);
    chk("rd4_cmd", {r, w}, 2'b10);
    for (int k = 0; k < 4; k++) beat(2'b01, 64'hA0 + k);
    chk("rd4_sb_drained", sb.size(), 0);
    chk("rd4_tags_empty", dut.u_tags.empty, 1'b1);

    // Simultaneous reads after reset: req0 first, then req1
    do_reset();
    set_bc(0, 5'd1); set_bc(1, 5'd1);
    bus.req_read = 2'b11;
    wait_accept(0, 4, cyc, a, bc, r, w);
    chk("rr_first_cycles", cyc, 1);
    chk("rr_first_addr", a, 33'h100);
    bus.req_read[0] = 1'b0;
    wait_accept(1, 4, cyc, a, bc, r, w);
    chk("rr_second_cycles", cyc, 1);
    chk("rr_second_addr", a, 33'h200);
    bus.req_read = '0;
    beat(2'b01, 64'hB0);
    beat(2'b10, 64'hB1);
    chk("rr_sb_drained", sb.size(), 0);

    // req1 8-beat write under toggling bank stall, req0 read held off
    set_bc(1, 5'd8); set_bc(0, 5'd1);
    bus.req_write[1] = 1'b1;
    nb = 0; nc = 0;
    while (nb < 8 && nc < 64) begin
      bus.ddr_waitrequest = nc[0];
      bus.req_writedata[DW +: 64] = 64'hC0 + 64'(nb);
      #4;
      if (nb > 0) chk("wb_req0_held", {bus.req_waitrequest[0], bus.ddr_read}, 2'b10);
      acc = !bus.req_waitrequest[1];
      if (acc) chk("wb_beat", {bus.ddr_write, bus.ddr_writedata[63:0]}, {1'b1, 64'hC0 + 64'(nb)});
      @(negedge clk);
      if (acc) nb++;
      if (nb >= 1) bus.req_read[0] = 1'b1;
      nc++;
    end
    chk("wb_beats", nb, 8);
    bus.req_write = '0;
    bus.ddr_waitrequest = 1'b0;
    wait_accept(0, 4, cyc, a, bc, r, w);
    chk("wb_then_read_cycles", cyc, 1);
    chk("wb_then_read_cmd", {r, a}, {1'b1, 33'h100});
    bus.req_read = '0;
    beat(2'b01, 64'hC8);
    chk("wb_sb_drained", sb.size(), 0);

    // Tag FIFO full: fifth read waits for the first tag to retire
    do_reset();
    set_bc(0, 5'd1);
    bus.req_read[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(0, 2, cyc, a, bc, r, w);
      chk($sformatf("full_rd%0d_cycles", k), cyc, 1);
    end
    chk("full_flag", dut.u_tags.full, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #4;
      chk("full_held", {bus.req_waitrequest[0], bus.ddr_read}, 2'b10);
      @(negedge clk);
    end
    bus.ddr_readdatavalid = 1'b1;
    bus.ddr_readdata = DW'(64'hD0);
    begin
      rsp_t e;
      e.oh = 2'b01; e.data = 64'hD0;
      sb.push_back(e);
    end
    #4;
    chk("full_pop_cycle_held", {bus.req_waitrequest[0], bus.ddr_read}, 2'b10);
    @(negedge clk);
    bus.ddr_readdatavalid = 1'b0;
    wait_accept(0, 2, cyc, a, bc, r, w);
    chk("full_fifth_cycles", cyc, 1);
    bus.req_read = '0;
    for (int k = 1; k <= 4; k++) beat(2'b01, 64'hD0 + 64'(k));
    chk("full_sb_drained", sb.size(), 0);
    chk("full_tags_empty", dut.u_tags.empty, 1'b1);

    // Reset in the middle of an 8-beat write
    set_bc(1, 5'd8);
    bus.req_write[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_accept(1, 2, cyc, a, bc, r, w);
      chk($sformatf("mid_beat%0d_cycles", k), cyc, 1);
    end
    chk("mid_state_burst", dut.state_q, WBURST);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_waitreq", bus.req_waitrequest, 2'b11);
    chk("mid_rst_ddr_cmd", {bus.ddr_read, bus.ddr_write}, 2'b00);
    chk("mid_rst_state", dut.state_q, IDLE);
    chk("mid_rst_rr", dut.rr_q, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_write = '0;
    set_bc(1, 5'd1);
    bus.req_read[1] = 1'b1;
    wait_accept(1, 2, cyc, a, bc, r, w);
    chk("mid_fresh_read_cycles", cyc, 1);
    chk("mid_fresh_read_cmd", {r, a}, {1'b1, 33'h200});
    bus.req_read = '0;
    beat(2'b10, 64'hE0);
    chk("mid_sb_drained", sb.size(), 0);

    // Read data valid with nothing outstanding
    chk("unexp_err_before", err, 1'b0);
    bus.ddr_readdatavalid = 1'b1;
    bus.ddr_readdata = DW'(64'hF0);
    #1;
    chk("unexp_rdv_dropped", bus.req_readdatavalid, 2'b00);
    @(negedge clk);
    bus.ddr_readdatavalid = 1'b0;
    #1;
    chk("unexp_err_set", err, 1'b1);
    repeat (3) @(negedge clk);
    chk("unexp_err_sticky", err, 1'b1);
    do_reset();
    #1;
    chk("unexp_err_cleared", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ddr4_bank_arbiter.md
Name: ddr4_bank_arbiter

Overview:
Shares one kernel-side DDR4 Avalon-MM bank port (33-bit address, 512-bit data, 5-bit burstcount) between NUM_REQ kernel load/store masters.
- Round-robin arbitration per command.
- Write bursts are locked to one requester until the burst completes.
- Read responses are routed back to their requester in order, using a tag FIFO.
- One instance sits in front of each kernel_ddr4a..d port inside the kernel system.

Parameters:
NUM_REQ, 2, number of requesting masters (2..4)
TAG_DEPTH, 8, maximum outstanding read bursts (power of 2)
ADDR_W, 33, address width
DATA_W, 512, data width
BC_W, 5, burstcount width

Ports:
clock_reset_clk  in  1  kernel clock; all logic on its rising edge
clock_reset_reset_reset_n  in  1  asynchronous active-low reset
req_address  in  NUM_REQ*ADDR_W  packed per-requester word addresses
req_byteenable  in  NUM_REQ*DATA_W/8  packed byteenables
req_read  in  NUM_REQ  read request per requester
req_write  in  NUM_REQ  write request per requester
req_writedata  in  NUM_REQ*DATA_W  packed write data
req_burstcount  in  NUM_REQ*BC_W  packed burstcounts
req_waitrequest  out  NUM_REQ  per-requester stall
req_readdata  out  DATA_W  shared read data, qualified by req_readdatavalid
req_readdatavalid  out  NUM_REQ  one-hot response valid
ddr_address/byteenable/read/write/writedata/burstcount  out  ADDR_W/DATA_W/8/1/1/DATA_W/BC_W  bank command
ddr_waitrequest  in  1  bank stall
ddr_readdata  in  DATA_W  bank read data
ddr_readdatavalid  in  1  bank read data valid
err_unexpected_rdv  out  1  sticky: readdatavalid arrived with no outstanding read

Behaviour:
- Reset (async assert, sync deassert upstream):
  - FSM=IDLE, rr pointer=0, tag FIFO empty, response beat counter=0, err_unexpected_rdv=0.
  - ddr_read/ddr_write=0, req_readdatavalid=0.
  - req_waitrequest forced all-ones while reset is low.
- FSM states: IDLE, WBURST.
- IDLE:
  - Winner = first requester with read|write, searching from the rr pointer upward with wrap.
  - The winner's command passes combinationally to the ddr_* outputs; zero added latency.
  - req_waitrequest[i] = (i!=grant) | ddr_waitrequest | (read & tag_full).
  - When a read is held off because tag_full, ddr_read=0.
- A command is accepted when (ddr_read|ddr_write) & ~ddr_waitrequest.
- Accepted read:
  - Push {id, burstcount} into the tag FIFO.
  - rr pointer = winner+1 mod NUM_REQ.
  - Stay in IDLE.
- Accepted write:
  - burstcount<=1: single beat; update rr; stay in IDLE.
  - burstcount>1: go to WBURST, lock id, beats_left=burstcount-1.
- WBURST:
  - Only the locked requester is passed to the bank; all others see waitrequest=1.
  - Each accepted beat decrements beats_left; the decrement holds across ddr_waitrequest stalls.
  - The beat that takes beats_left to 0 returns the FSM to IDLE and sets rr = locked id+1.
- If both read and write are asserted by one requester, read takes precedence. This is a protocol violation; it is not checked.
- burstcount=0 is treated as 1 for tag and beat accounting.
- Responses:
  - req_readdata = ddr_readdata, combinational.
  - req_readdatavalid = onehot(head.id) & ddr_readdatavalid, combinational.
  - A beat counter starts at head.burstcount. The last beat pops the FIFO.
  - Push and pop in the same cycle are allowed. When the FIFO is full, a push is blocked even if a pop happens in the same cycle.
- ddr_readdatavalid with tag FIFO empty: data is dropped, req_readdatavalid=0, err_unexpected_rdv set (cleared only by reset).
- Reset mid-burst abandons any partial burst and all outstanding tags; the bank must be reset together with this block.

Decomposition:
- Package kernel_mem_pkg:
  - ADDR_W, DATA_W, BE_W, BC_W constants.
  - typedef rd_tag_t {id[$clog2(NUM_REQ)], bc[BC_W]}.
  - enum arb_state_t {IDLE, WBURST}.
- Sub-module ddr_rsp_tag_fifo: synchronous FIFO holding rd_tag_t, TAG_DEPTH entries, full/empty flags, registered head. It uses the same clock and asynchronous reset.

Test Plan:
- req0 reads addr 0x100 with burstcount 4, bank returns 4 beats -> ddr_burstcount=4; req_readdatavalid=2'b01 for exactly 4 cycles; tag FIFO empty afterwards.
- After reset, req0 and req1 both read in the same cycle -> req0 granted first and req1 the next accepted cycle; responses delivered 01 then 10, in order.
- req1 writes burstcount 8 with ddr_waitrequest toggling, while req0 holds a read -> req0 stalled until all 8 req1 beats are accepted; req0's read is issued on the next cycle.
- TAG_DEPTH=4, 4 single-beat-burst reads outstanding, 5th read -> waitrequest held and ddr_read=0 until the first response pops a tag, then the 5th read is accepted.
- Reset asserted after 3 of 8 write beats -> FSM IDLE, rr=0, req_waitrequest all ones during reset; a fresh req1 read is granted after release.
- ddr_readdatavalid pulsed with no outstanding read -> req_readdatavalid=0, err_unexpected_rdv=1 and stays 1 until reset.
